// File: rtl/dpll_pkg.sv
// Shared constants for the XOR/K-counter DPLL lock controller.
package dpll_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ACQUIRE = 3'd1;
    localparam logic [2:0] ST_TRACK   = 3'd2;
    localparam logic [2:0] ST_NOREF   = 3'd3;

    localparam logic [7:0] K_FAST_DEF = 8'h10;
    localparam logic [7:0] K_SLOW_DEF = 8'hFF;

    // dev = |2*xor - per| needs one bit for the doubling and one for the sign headroom.
    localparam int unsigned DEV_EXTRA_W = 2;

endpackage

// File: rtl/dpll_lock_ctrl_phase_meas.sv
// Phase measurement: clk_in synchronizer, edge detect, per-period period/XOR counters
// and the deviation-from-50%-duty test.
module dpll_phase_meas
    import dpll_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TOL   = 4
) (
    input  logic                         clk_ref,
    input  logic                         rst,
    input  logic                         clk_in,
    input  logic                         clk_out,
    input  logic                         hold,
    input  logic                         unprime,
    output logic                         ref_edge_c,
    output logic                         result_valid,
    output logic                         good,
    output logic [CNT_W-1:0]             per_cnt,
    output logic [CNT_W+DEV_EXTRA_W-1:0] dev
);

    localparam int unsigned      DEV_W   = CNT_W + DEV_EXTRA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             in_s1, in_s2, in_s3, out_d2, xor_bit, primed;
    logic [CNT_W-1:0] xor_cnt, per_inc, xor_inc;
    logic [DEV_W-1:0] twice_xor, per_ext;

    assign ref_edge_c = in_s2 & ~in_s3;
    assign xor_bit    = in_s2 ^ out_d2;

    // Results include the edge cycle itself, so a P-cycle period reports per = P.
    assign per_inc = (per_cnt == CNT_MAX) ? per_cnt : per_cnt + CNT_W'(1);
    assign xor_inc = (xor_cnt == CNT_MAX || !xor_bit) ? xor_cnt : xor_cnt + CNT_W'(1);

    assign twice_xor    = DEV_W'({xor_inc, 1'b0});
    assign per_ext      = DEV_W'(per_inc);
    assign dev          = (twice_xor >= per_ext) ? twice_xor - per_ext : per_ext - twice_xor;
    assign good         = (dev <= DEV_W'(TOL)) && (per_inc != CNT_MAX);
    assign result_valid = ref_edge_c & primed & ~hold;

    // The first edge after hold/unprime only restarts the counters.
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            in_s1   <= 1'b0;
            in_s2   <= 1'b0;
            in_s3   <= 1'b0;
            out_d2  <= 1'b0;
            per_cnt <= '0;
            xor_cnt <= '0;
            primed  <= 1'b0;
        end else begin
            in_s1  <= clk_in;
            in_s2  <= in_s1;
            in_s3  <= in_s2;
            out_d2 <= clk_out;
            if (hold) begin
                per_cnt <= '0;
                xor_cnt <= '0;
                primed  <= 1'b0;
            end else begin
                if (ref_edge_c) begin
                    per_cnt <= '0;
                    xor_cnt <= '0;
                    primed  <= 1'b1;
                end else begin
                    per_cnt <= per_inc;
                    xor_cnt <= xor_inc;
                end
                if (unprime) begin
                    primed <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/dpll_lock_ctrl.sv
// DPLL acquisition/lock controller (clk_ref domain): selects K modulus, reports lock,
// loss-of-lock and missing reference. DPLL_LOCK_STATS_EN adds lol_count/last_dev.
module dpll_lock_ctrl
    import dpll_pkg::*;
#(
    parameter int unsigned      CNT_W    = 16,
    parameter int unsigned      K_W      = 8,
    parameter logic [K_W-1:0]   K_FAST   = K_W'(K_FAST_DEF),
    parameter logic [K_W-1:0]   K_SLOW   = K_W'(K_SLOW_DEF),
    parameter int unsigned      TOL      = 4,
    parameter int unsigned      LOCK_N   = 8,
    parameter int unsigned      UNLOCK_N = 4,
    parameter logic [CNT_W-1:0] TIMEOUT  = CNT_W'(16'hFFFF)
) (
    input  logic           clk_ref,
    input  logic           rst,
    input  logic           en,
    input  logic           clk_in,
    input  logic           clk_out,
    output logic [K_W-1:0] k_mod,
    output logic           locked,
    output logic           lol_pulse,
    output logic           no_ref,
    output logic [2:0]     state_o
`ifdef DPLL_LOCK_STATS_EN
    ,
    output logic [15:0]    lol_count,
    output logic [CNT_W+1:0] last_dev
`endif
);

    localparam int unsigned RUN_MAX = (LOCK_N > UNLOCK_N) ? LOCK_N : UNLOCK_N;
    localparam int unsigned RUN_W   = $clog2(RUN_MAX + 1);

    logic [2:0]                   state, state_next;
    logic [RUN_W-1:0]             good_run, good_next, bad_run, bad_next;
    logic                         lol_next, unprime_c, hold_c, timeout_c;
    logic                         ref_edge_c, result_valid, good;
    logic [CNT_W-1:0]             per_cnt;
    logic [CNT_W+DEV_EXTRA_W-1:0] dev;

    assign hold_c    = (state == ST_IDLE);
    assign timeout_c = (per_cnt >= TIMEOUT);
    assign state_o   = state;

    dpll_phase_meas #(
        .CNT_W (CNT_W),
        .TOL   (TOL)
    ) u_meas (
        .clk_ref      (clk_ref),
        .rst          (rst),
        .clk_in       (clk_in),
        .clk_out      (clk_out),
        .hold         (hold_c),
        .unprime      (unprime_c),
        .ref_edge_c   (ref_edge_c),
        .result_valid (result_valid),
        .good         (good),
        .per_cnt      (per_cnt),
        .dev          (dev)
    );

    // Next state; priority is en low, then timeout, then the period result.
    always_comb begin
        state_next = state;
        good_next  = good_run;
        bad_next   = bad_run;
        lol_next   = 1'b0;
        unprime_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (en) state_next = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
                if (timeout_c) begin
                    state_next = ST_NOREF;
                    unprime_c  = 1'b1;
                end else if (result_valid) begin
                    if (!good)                                good_next  = '0;
                    else if (good_run == RUN_W'(LOCK_N - 1))  state_next = ST_TRACK;
                    else                                      good_next  = good_run + RUN_W'(1);
                end
            end
            ST_TRACK: begin
                if (timeout_c) begin
                    state_next = ST_NOREF;
                    unprime_c  = 1'b1;
                    lol_next   = 1'b1;
                end else if (result_valid) begin
                    if (good) begin
                        bad_next = '0;
                    end else if (bad_run == RUN_W'(UNLOCK_N - 1)) begin
                        state_next = ST_ACQUIRE;
                        lol_next   = 1'b1;
                    end else begin
                        bad_next = bad_run + RUN_W'(1);
                    end
                end
            end
            ST_NOREF: begin
                if (ref_edge_c) state_next = ST_ACQUIRE;
            end
            default: state_next = ST_IDLE;
        endcase
        if (!en) begin
            state_next = ST_IDLE;
            lol_next   = 1'b0;
            unprime_c  = 1'b0;
        end
        if (state_next != state) begin
            good_next = '0;
            bad_next  = '0;
        end
    end

    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            good_run  <= '0;
            bad_run   <= '0;
            k_mod     <= K_FAST;
            locked    <= 1'b0;
            lol_pulse <= 1'b0;
            no_ref    <= 1'b0;
        end else begin
            state     <= state_next;
            good_run  <= good_next;
            bad_run   <= bad_next;
            k_mod     <= (state_next == ST_TRACK) ? K_SLOW : K_FAST;
            locked    <= (state_next == ST_TRACK);
            lol_pulse <= lol_next;
            no_ref    <= (state_next == ST_NOREF);
        end
    end

`ifdef DPLL_LOCK_STATS_EN
    always_ff @(posedge clk_ref or posedge rst) begin
        if (rst) begin
            lol_count <= '0;
            last_dev  <= '0;
        end else begin
            if (lol_next && lol_count != 16'hFFFF) lol_count <= lol_count + 16'd1;
            if (result_valid)                      last_dev  <= dev;
        end
    end
`else
    logic unused_dev_c;
    assign unused_dev_c = ^dev;
`endif

endmodule

// File: doc/dpll_lock_ctrl.md
Name: dpll_lock_ctrl

Overview:
- Acquisition and lock controller for the TI-style XOR/K-counter DPLL; runs entirely in the clk_ref domain.
- Measures XOR phase-detector duty once per clk_in period and selects the K-counter modulus: a short K for fast acquisition, a long K for low-jitter tracking.
- Reports lock status and loss-of-lock events, and detects a missing reference.

Parameters:
- CNT_W, 16, width of period/XOR measurement counters (saturating).
- K_W, 8, width of the K modulus output.
- K_FAST, 8'h10, K modulus driven in ACQUIRE.
- K_SLOW, 8'hFF, K modulus driven in TRACK.
- TOL, 4, max allowed |2*xor_cnt - per_cnt|, in clk_ref cycles, for a "good" period.
- LOCK_N, 8, consecutive good periods needed to enter TRACK.
- UNLOCK_N, 4, consecutive bad periods needed to leave TRACK.
- TIMEOUT, 16'hFFFF, clk_ref cycles without a clk_in rising edge before declaring no reference.

Ports:
- clk_ref  in  1  DPLL reference clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  controller enable; low forces IDLE.
- clk_in  in  1  DPLL input clock, asynchronous to clk_ref.
- clk_out  in  1  DPLL output clock, generated from clk_ref.
- k_mod  out  K_W  K-counter modulus to the DPLL.
- locked  out  1  high in TRACK only.
- lol_pulse  out  1  one-cycle loss-of-lock strobe.
- no_ref  out  1  high in NOREF.
- state_o  out  3  current FSM state encoding.

Behaviour:
- Reset values: k_mod = K_FAST, locked = 0, lol_pulse = 0, no_ref = 0, state = IDLE; all counters 0.
- Input conditioning:
  - clk_in passes through a 2-flop synchronizer, then a third flop for edge detection; edge = rising edge of the synchronized signal.
  - clk_out is registered once so both inputs see matching 2-cycle alignment (XOR = sync_in ^ out_d2).
- Measurement, per period:
  - per_cnt and xor_cnt both saturate at 2^CNT_W-1.
  - per_cnt increments every cycle; xor_cnt increments when XOR = 1.
  - On edge: a result is evaluated from the pre-edge counts, then both counters load 0.
  - The first edge after leaving IDLE/NOREF only primes the counters and produces no result.
- Good-period test: dev = |2*xor_cnt - per_cnt| computed at CNT_W+2 bits; good = (dev <= TOL) and per_cnt not saturated. The target is 50% XOR duty, i.e. 90° lock.
- FSM states: IDLE=0, ACQUIRE=1, TRACK=2, NOREF=3.
  - IDLE: go to ACQUIRE when en = 1.
  - ACQUIRE:
    - k_mod = K_FAST.
    - good_run counts consecutive good results; a bad result clears it.
    - When good_run reaches LOCK_N, go to TRACK the same cycle.
  - TRACK:
    - k_mod = K_SLOW, locked = 1.
    - bad_run counts consecutive bad results; a good result clears it.
    - When bad_run reaches UNLOCK_N, go to ACQUIRE and pulse lol_pulse for one cycle.
  - NOREF: no_ref = 1, k_mod = K_FAST; the first clk_in edge goes to ACQUIRE (that edge is the priming edge).
  - Any non-IDLE state: per_cnt reaching TIMEOUT with no edge goes to NOREF. lol_pulse also fires if this exit is from TRACK.
  - en = 0 from any state goes to IDLE next cycle, with no lol_pulse.
- Outputs are registered: locked, k_mod and no_ref change 1 cycle after the state transition condition.
- Priority when events coincide: en = 0 > timeout > edge result.
- The good_run/bad_run counter not used by the current state is held at 0. Both clear on every state change.
- Reset mid-operation returns immediately to the reset values; the synchronizer flops also clear.

Optional Feature:
- Macro: DPLL_LOCK_STATS_EN.
- Defined:
  - Adds output lol_count[15:0], which increments (saturating) on every lol_pulse and resets to 0 only on rst.
  - Adds output last_dev[CNT_W+1:0], the dev value of the most recent result; reset 0.
- Undefined: neither port exists and no related logic is built.

Decomposition:
- Package dpll_pkg:
  - state encoding constants.
  - default K_FAST/K_SLOW values.
  - dev width helper constant.
- One sub-module: dpll_phase_meas. It contains the synchronizer, edge detect, per/xor counters and dev/good computation. It outputs result_valid, good, per_cnt and dev.
- The FSM stays in dpll_lock_ctrl.

Test Plan:
- Reset and enable: assert rst mid-TRACK -> locked = 0, k_mod = K_FAST, state_o = 0 immediately; raise en -> state_o = 1 next cycle.
- Acquire to lock: clk_in period 64, clk_out phase 90° (xor_cnt = 32) -> after priming edge plus 8 periods, locked = 1, k_mod = 8'hFF.
- Tolerance edge: per = 64, xor = 34 (dev = 4) counts good; xor = 35 (dev = 6) counts bad and resets good_run.
- Unlock: in TRACK, 3 bad periods then 1 good -> stays locked; 4 consecutive bad -> lol_pulse for exactly 1 cycle, state ACQUIRE, k_mod = K_FAST.
- Reference loss: stop clk_in in TRACK -> after TIMEOUT cycles, no_ref = 1 and lol_pulse fires; restart clk_in -> ACQUIRE, with no result from the first edge.
- With DPLL_LOCK_STATS_EN: two unlock events -> lol_count = 2; last_dev matches the dev of the final period.
